alu_share_ctrl: RTL and testbench

- Shares one combinational 32-bit PE ALU (4-bit op select, Zero flag) among NREQ requesters, such as neighbouring CGRA tiles or PE issue slots.
- Round-robin arbitration with a valid/ready handshake on each request.
- Registers the operands and holds them stable for a per-op execution time. Mul, div and SRA are multicycle paths.
- Returns a tagged result on one shared response channel with backpressure.

---
 rtl/alu_share_ctrl_pkg.sv | 40 ++++
 rtl/alu_share_ctrl_rr_arbiter.sv | 41 ++++
 rtl/alu_share_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : alu_share_ctrl_pkg
// Brief   : ALU op codes, controller state encoding and op classification.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_share_ctrl_pkg;

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_mul  = 4'b0010;
    localparam logic [3:0] c_op_div  = 4'b0011;
    localparam logic [3:0] c_op_sll1 = 4'b0100;
    localparam logic [3:0] c_op_srl1 = 4'b0101;
    localparam logic [3:0] c_op_rol  = 4'b0110;
    localparam logic [3:0] c_op_ror  = 4'b0111;
    localparam logic [3:0] c_op_and  = 4'b1000;
    localparam logic [3:0] c_op_or   = 4'b1001;
    localparam logic [3:0] c_op_xor  = 4'b1010;
    localparam logic [3:0] c_op_nor  = 4'b1011;
    localparam logic [3:0] c_op_nand = 4'b1100;
    localparam logic [3:0] c_op_sltu = 4'b1101;
    localparam logic [3:0] c_op_slt  = 4'b1110;
    localparam logic [3:0] c_op_sra  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ops whose ALU paths are constrained as multicycle.
    function automatic logic is_long_op(input logic [3:0] sel);
        return (sel == c_op_mul) || (sel == c_op_div) || (sel == c_op_sra);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; searches upward from i_ptr+1.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_gnt_idx,
    output logic         o_any
);

    localparam logic [W-1:0] c_last = W'(N - 1);

    logic [W-1:0] w_cand;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_cand    = i_ptr;
        // Walk the N candidates after the pointer with explicit modulo-N wrap.
        for (int k = 0; k < N; k++) begin
            w_cand = (w_cand == c_last) ? '0 : w_cand + 1'b1;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_gnt_idx     = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
//------------------------------------------------------------------------------
// Module  : alu_share_ctrl
// Brief   : Round-robin sharing of one combinational ALU among NREQ requesters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int LONG_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]    req_sel,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_sel,
    input  logic [31:0]          alu_out,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_divz,
    output logic                 busy,
    output logic [31:0]          ops_done
);

    localparam int c_cntw = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [c_cntw-1:0] c_long_load = c_cntw'(LONG_CYCLES - 1);

    state_t              r_state;
    logic [IDW-1:0]      r_ptr;
    logic [c_cntw-1:0]   r_cnt;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [3:0]          r_sel;
    logic [IDW-1:0]      r_gid;
    logic                r_rsp_valid;
    logic [IDW-1:0]      r_rsp_id;
    logic [31:0]         r_rsp_data;
    logic                r_rsp_zero;
    logic                r_rsp_divz;
    logic [31:0]         r_ops_done;

    logic [NREQ-1:0]     w_gnt;
    logic [IDW-1:0]      w_gidx;
    logic                w_any;
    logic [31:0]         w_a   [NREQ];
    logic [31:0]         w_b   [NREQ];
    logic [3:0]          w_sel [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_a[i]   = req_a[32*i +: 32];
        assign w_b[i]   = req_b[32*i +: 32];
        assign w_sel[i] = req_sel[4*i +: 4];
    end

    rr_arbiter #(
        .N (NREQ),
        .W (IDW)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gidx),
        .o_any     (w_any)
    );

    // The grant is only offered while the ALU is free.
    assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_gid       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_divz  <= 1'b0;
            r_ops_done  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_a[w_gidx];
                        r_b     <= w_b[w_gidx];
                        r_sel   <= w_sel[w_gidx];
                        r_gid   <= w_gidx;
                        r_ptr   <= w_gidx;
                        r_cnt   <= is_long_op(w_sel[w_gidx]) ? c_long_load : '0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_data  <= alu_out;
                        r_rsp_zero  <= alu_zero;
                        r_rsp_divz  <= (r_sel == c_op_div) && (r_b == '0);
                        r_rsp_id    <= r_gid;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 32'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_sel   = r_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_divz  = r_rsp_divz;
    assign busy      = (r_state != ST_IDLE);
    assign ops_done  = r_ops_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_alu_share_ctrl
// Brief   : Directed, table-driven bench for alu_share_ctrl with a model ALU.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LC   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [4*NREQ-1:0]    req_sel;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [3:0]           alu_sel;
    logic [31:0]          alu_out;
    logic                 alu_zero;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_zero;
    logic                 rsp_divz;
    logic                 busy;
    logic [31:0]          ops_done;

    alu_share_ctrl #(
        .NREQ        (NREQ),
        .IDW         (IDW),
        .LONG_CYCLES (LC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_divz  (rsp_divz),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    // Reference combinational PE ALU driven by the controller.
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            c_op_add:  alu_out = alu_a + alu_b;
            c_op_sub:  alu_out = alu_a - alu_b;
            c_op_mul:  alu_out = alu_a * alu_b;
            c_op_div:  alu_out = (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            c_op_sll1: alu_out = alu_a << 1;
            c_op_srl1: alu_out = alu_a >> 1;
            c_op_rol:  alu_out = {alu_a[30:0], alu_a[31]};
            c_op_ror:  alu_out = {alu_a[0], alu_a[31:1]};
            c_op_and:  alu_out = alu_a & alu_b;
            c_op_or:   alu_out = alu_a | alu_b;
            c_op_xor:  alu_out = alu_a ^ alu_b;
            c_op_nor:  alu_out = ~(alu_a | alu_b);
            c_op_nand: alu_out = ~(alu_a & alu_b);
            c_op_sltu: alu_out = {31'd0, alu_a < alu_b};
            c_op_slt:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            c_op_sra:  alu_out = $signed(alu_a) >>> alu_b[4:0];
            default:   alu_out = '0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    typedef struct {
        int          id;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        zero;
        logic        divz;
        int          lat;
    } vec_t;

    vec_t        vecs [9];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sel[4*i +: 4] = sel;
        req_valid[i]      = 1'b1;
    endtask

    // Issue one lone request, follow it through EXEC and RESP, then handshake.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        set_req(v.id, v.sel, v.a, v.b);
        #1 check({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << v.id));
        @(negedge clk);
        req_valid[v.id] = 1'b0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            check({tag, "_alu_hold"}, {alu_sel, alu_a[27:0] ^ alu_b[27:0]},
                  {v.sel, v.a[27:0] ^ v.b[27:0]});
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(v.lat));
        check({tag, "_id"}, 32'(rsp_id), 32'(v.id));
        check({tag, "_data"}, rsp_data, v.data);
        check({tag, "_flags"}, {30'd0, rsp_zero, rsp_divz}, {30'd0, v.zero, v.divz});
        @(negedge clk);
        exp_ops = exp_ops + 32'd1;
        check({tag, "_rsp_clr"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_ops_done"}, ops_done, exp_ops);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic seen;
        logic [31:0] rr_data [4];

        vecs[0] = '{0, c_op_add,  32'd5,           32'd7,           32'd12,          1'b0, 1'b0, 2};
        vecs[1] = '{2, c_op_div,  32'd100,         32'd0,           32'hFFFF_FFFF,   1'b0, 1'b1, 5};
        vecs[2] = '{1, c_op_sub,  32'd9,           32'd9,           32'd0,           1'b1, 1'b0, 2};
        vecs[3] = '{3, c_op_mul,  32'd6,           32'd7,           32'd42,          1'b0, 1'b0, 5};
        vecs[4] = '{1, c_op_div,  32'd100,         32'd7,           32'd14,          1'b0, 1'b0, 5};
        vecs[5] = '{2, c_op_sra,  32'h8000_0000,   32'd4,           32'hF800_0000,   1'b0, 1'b0, 5};
        vecs[6] = '{3, c_op_xor,  32'hFF00_FF00,   32'h0FF0_0FF0,   32'hF0F0_F0F0,   1'b0, 1'b0, 2};
        vecs[7] = '{0, c_op_and,  32'h0000_00F0,   32'h0000_000F,   32'd0,           1'b1, 1'b0, 2};
        vecs[8] = '{2, c_op_sltu, 32'd1,           32'd2,           32'd1,           1'b0, 1'b0, 2};
        rr_data[0] = 32'd10;
        rr_data[1] = 32'd19;
        rr_data[2] = 32'd28;
        rr_data[3] = 32'd37;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        exp_ops   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_ops_done", ops_done, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b_sel", {alu_sel, alu_b[27:0]}, 32'd0);
        check("rst_rsp_fields", {rsp_data[28:0], rsp_id, rsp_zero ^ rsp_divz}, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // Directed single-requester vectors.
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Round-robin with all requesters continuously asserted.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, c_op_sub, 32'(10 * (i + 1)), 32'(i));
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (busy !== 1'b0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            #1 check($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(negedge clk);
            n = 0;
            while (rsp_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(k % 4));
            check($sformatf("rr%0d_data", k), rsp_data, rr_data[k % 4]);
            @(negedge clk);
            exp_ops = exp_ops + 32'd1;
        end
        req_valid = '0;
        check("rr_ops_done", ops_done, exp_ops);

        // Backpressure: response held while a second requester waits.
        rsp_ready = 1'b0;
        @(negedge clk);
        set_req(1, c_op_sub, 32'd9, 32'd9);
        set_req(3, c_op_add, 32'd1, 32'd2);
        #1 check("bp_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1 check("bp_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i),
                  {rsp_valid, rsp_zero, rsp_id, req_ready, rsp_data[23:0]},
                  {1'b1, 1'b1, 2'd1, 4'b0000, 24'd0});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_ops = exp_ops + 32'd1;
        #1;
        check("bp_released", {31'd0, rsp_valid}, 32'd0);
        check("bp_grant3", 32'(req_ready), 32'b1000);
        check("bp_ops_done", ops_done, exp_ops);
        @(negedge clk);
        req_valid[3] = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_r3_result", {rsp_id, rsp_data[29:0]}, {2'd3, 30'd3});
        @(negedge clk);

        // Reset in the middle of a long op.
        set_req(0, c_op_mul, 32'd3, 32'd4);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = '0;
        check("mid_rst_state", {busy, rsp_valid, alu_sel, alu_a[25:0]}, 32'd0);
        check("mid_rst_ops", ops_done, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("mid_no_rsp", {31'd0, seen}, 32'd0);

        // Counter wrap.
        @(negedge clk);
        force dut.r_ops_done = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_ops_done;
        #1 check("wrap_preload", ops_done, 32'hFFFF_FFFF);
        exp_ops = 32'hFFFF_FFFF;
        run_vec(vecs[0], "wrap");
        check("wrap_zero", ops_done, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
